// File: rtl/multdiv_scheduler_pkg.sv
// Shared processor constants for the mult/div writeback scheduler.
package multdiv_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_t;

  localparam int MD_TIMEOUT  = 40;
  localparam int RSTATUS_NUM = 30;
  localparam int MULT_CODE   = 4;
  localparam int DIV_CODE    = 5;

endpackage

// File: rtl/multdiv_hazard_check.sv
// Decode-stage hazard detector against an in-flight (or just-issued) mult/div.
module multdiv_hazard_check (
  input  logic       dec_valid,
  input  logic       active,
  input  logic       dec_is_multdiv,
  input  logic [4:0] dec_rs,
  input  logic [4:0] dec_rt,
  input  logic [4:0] pending_rd,
  output logic       stall
);

  logic rd_live;

  // Stall a live decode that needs the unit or reads the pending destination.
  always_comb begin
    rd_live = (pending_rd != '0);
    stall   = dec_valid & active &
              (dec_is_multdiv |
               (rd_live & (dec_rs == pending_rd)) |
               (rd_live & (dec_rt == pending_rd)));
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Issues mult/div ops to the multdiv unit, waits for the result (with a
// timeout abort) and writes it back when the main pipeline leaves the port free.
module multdiv_scheduler
  import multdiv_scheduler_pkg::*;
#(
  parameter int TIMEOUT     = MD_TIMEOUT,
  parameter int RSTATUS_REG = RSTATUS_NUM,
  parameter int MULT_EXC    = MULT_CODE,
  parameter int DIV_EXC     = DIV_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [4:0]  issue_rd,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        dec_is_multdiv,
  input  logic        pipe_wb_en,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_wb_en,
  output logic [4:0]  md_wb_reg,
  output logic [31:0] md_wb_data,
  output logic        should_stall,
  output logic        busy
);

  md_state_t   state;
  md_state_t   state_next;
  logic [5:0]  cnt;
  logic [4:0]  rd_q;
  logic        div_q;
  logic        exc_q;
  logic [31:0] result_q;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic        accept;
  logic        timeout_hit;
  logic        wb_fire;
  logic [4:0]  pending_rd;

  // Acceptance is gated by reset so should_stall stays low while in reset.
  always_comb begin
    accept      = reset && (state == IDLE) && (issue_mult || issue_div);
    timeout_hit = (cnt == 6'(TIMEOUT - 1));
    pending_rd  = (state == IDLE) ? issue_rd : rd_q;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (md_resultRDY || timeout_hit) state_next = WB;
      WB:      if (!pipe_wb_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Op latch, cycle counter, result capture and one-cycle start pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rd_q        <= '0;
      div_q       <= 1'b0;
      exc_q       <= 1'b0;
      result_q    <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            rd_q        <= issue_rd;
            div_q       <= !issue_mult;
            exc_q       <= 1'b0;
            ctrl_mult_q <= issue_mult;
            ctrl_div_q  <= !issue_mult;
          end
        end
        BUSY: begin
          cnt <= cnt + 6'd1;
          if (md_resultRDY) begin
            result_q <= md_result;
            exc_q    <= md_exception;
          end else if (timeout_hit) begin
            exc_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs; a clean result to r0 retires without touching the regfile.
  always_comb begin
    busy       = (state == BUSY) || (state == WB);
    wb_fire    = (state == WB) && !pipe_wb_en && (exc_q || (rd_q != '0));
    md_wb_en   = wb_fire;
    md_wb_reg  = '0;
    md_wb_data = '0;
    if (wb_fire) begin
      if (exc_q) begin
        md_wb_reg  = 5'(RSTATUS_REG);
        md_wb_data = div_q ? 32'(DIV_EXC) : 32'(MULT_EXC);
      end else begin
        md_wb_reg  = rd_q;
        md_wb_data = result_q;
      end
    end
  end

  assign ctrl_MULT = ctrl_mult_q;
  assign ctrl_DIV  = ctrl_div_q;

  multdiv_hazard_check u_hazard (
    .dec_valid      (dec_valid),
    .active         (busy | accept),
    .dec_is_multdiv (dec_is_multdiv),
    .dec_rs         (dec_rs),
    .dec_rt         (dec_rt),
    .pending_rd     (pending_rd),
    .stall          (should_stall)
  );

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench with a writeback scoreboard for multdiv_scheduler.
module tb_multdiv_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_mult, issue_div;
  logic [4:0]  issue_rd;
  logic        dec_valid;
  logic [4:0]  dec_rs, dec_rt;
  logic        dec_is_multdiv;
  logic        pipe_wb_en;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_exception;
  logic        ctrl_MULT, ctrl_DIV;
  logic        md_wb_en;
  logic [4:0]  md_wb_reg;
  logic [31:0] md_wb_data;
  logic        should_stall, busy;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clock = ~clock;

  multdiv_scheduler #(
    .TIMEOUT     (40),
    .RSTATUS_REG (30),
    .MULT_EXC    (4),
    .DIV_EXC     (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_mult     (issue_mult),
    .issue_div      (issue_div),
    .issue_rd       (issue_rd),
    .dec_valid      (dec_valid),
    .dec_rs         (dec_rs),
    .dec_rt         (dec_rt),
    .dec_is_multdiv (dec_is_multdiv),
    .pipe_wb_en     (pipe_wb_en),
    .md_resultRDY   (md_resultRDY),
    .md_result      (md_result),
    .md_exception   (md_exception),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .md_wb_en       (md_wb_en),
    .md_wb_reg      (md_wb_reg),
    .md_wb_data     (md_wb_data),
    .should_stall   (should_stall),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic issue(input bit div, input logic [4:0] rd);
    tick();
    issue_mult = !div;
    issue_div  = div;
    issue_rd   = rd;
    tick();
    issue_mult = 1'b0;
    issue_div  = 1'b0;
  endtask

  task automatic respond(input int lat, input logic [31:0] res, input bit exc);
    repeat (lat) tick();
    md_resultRDY = 1'b1;
    md_result    = res;
    md_exception = exc;
    tick();
    md_resultRDY = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk(name, busy, 0);
  endtask

  // Scoreboard monitor: every regfile write must match the next expected one.
  always @(negedge clock) begin
    wr_t w;
    if (md_wb_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=reg%0d/%0h required=none", md_wb_reg, md_wb_data);
      end else begin
        w = exp_q.pop_front();
        chk("wb_reg", 64'(md_wb_reg), 64'(w.r));
        chk("wb_data", 64'(md_wb_data), 64'(w.d));
      end
      chk("wb_port_conflict", 64'(pipe_wb_en), 0);
    end else begin
      chk("wb_idle_zero", {27'd0, md_wb_reg, md_wb_data}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; issue_mult = 1'b0; issue_div = 1'b0; issue_rd = '0;
    dec_valid = 1'b0; dec_rs = '0; dec_rt = '0; dec_is_multdiv = 1'b0;
    pipe_wb_en = 1'b0; md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
    repeat (3) tick();
    issue_mult = 1'b1; issue_rd = 5'd5; dec_valid = 1'b1; dec_is_multdiv = 1'b1;
    @(negedge clock);
    chk("reset_outputs", {23'd0, ctrl_MULT, ctrl_DIV, md_wb_en, md_wb_reg, md_wb_data, should_stall, busy}, 0);

    // mult rd=5, first edge after reset accepts, result 0x30
    tick();
    reset = 1'b1; dec_is_multdiv = 1'b0; dec_rs = 5'd5; dec_rt = 5'd1;
    push(5'd5, 32'h30);
    @(negedge clock);
    chk("stall_accept_cycle", should_stall, 1);
    chk("busy_before_accept", busy, 0);
    tick();
    issue_mult = 1'b0; dec_valid = 1'b0;
    @(negedge clock);
    chk("ctrl_mult_pulse", {ctrl_MULT, ctrl_DIV}, 2'b10);
    chk("busy_after_accept", busy, 1);
    tick();
    @(negedge clock);
    chk("ctrl_mult_one_cycle", ctrl_MULT, 0);
    respond(14, 32'h30, 0);
    @(negedge clock);
    chk("mult_write", md_wb_en, 1);
    tick();
    @(negedge clock);
    chk("mult_back_idle", {busy, md_wb_en}, 0);

    // div rd=7 with exception; an issue while busy is ignored
    push(5'd30, 32'h5);
    issue(1'b1, 5'd7);
    @(negedge clock);
    chk("ctrl_div_pulse", {ctrl_MULT, ctrl_DIV}, 2'b01);
    tick();
    issue_mult = 1'b1; issue_rd = 5'd20;
    tick();
    issue_mult = 1'b0;
    @(negedge clock);
    chk("busy_issue_ignored", {ctrl_MULT, ctrl_DIV}, 0);
    respond(3, 32'hDEAD, 1);
    @(negedge clock);
    chk("div_exc_write", md_wb_en, 1);
    wait_idle("div_exc_idle");

    // mult and div together: mult wins (exception code reveals op type)
    push(5'd30, 32'h4);
    tick();
    issue_mult = 1'b1; issue_div = 1'b1; issue_rd = 5'd3;
    tick();
    issue_mult = 1'b0; issue_div = 1'b0;
    @(negedge clock);
    chk("both_issue_mult_wins", {ctrl_MULT, ctrl_DIV}, 2'b10);
    respond(2, 32'h0, 1);
    wait_idle("both_issue_idle");

    // pipeline owns the port for 3 WB cycles; write lands in the 4th
    push(5'd12, 32'h1234_5678);
    issue(1'b0, 5'd12);
    respond(4, 32'h1234_5678, 0);
    pipe_wb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("wb_held", {busy, md_wb_en}, 2'b10);
      tick();
    end
    pipe_wb_en = 1'b0;
    @(negedge clock);
    chk("wb_after_hold", md_wb_en, 1);
    tick();
    @(negedge clock);
    chk("hold_back_idle", busy, 0);

    // hazard checks while rd=9 is pending
    push(5'd9, 32'hABCD);
    issue(1'b0, 5'd9);
    dec_valid = 1'b1;
    begin
      logic [4:0] rs_t [4] = '{5'd9, 5'd2, 5'd3, 5'd3};
      logic [4:0] rt_t [4] = '{5'd1, 5'd9, 5'd4, 5'd4};
      logic       md_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       ex_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        dec_rs = rs_t[i]; dec_rt = rt_t[i]; dec_is_multdiv = md_t[i];
        @(negedge clock);
        chk($sformatf("hazard_row%0d", i), should_stall, ex_t[i]);
        tick();
      end
    end
    dec_valid = 1'b0; dec_rs = 5'd9; dec_is_multdiv = 1'b0;
    @(negedge clock);
    chk("hazard_dec_invalid", should_stall, 0);
    respond(1, 32'hABCD, 0);
    wait_idle("hazard_op_idle");

    // rd=0: no RAW hazard on r0, and a clean result is never written
    issue(1'b0, 5'd0);
    dec_valid = 1'b1; dec_rs = 5'd0; dec_rt = 5'd0;
    @(negedge clock);
    chk("hazard_rd0", should_stall, 0);
    dec_valid = 1'b0;
    respond(1, 32'h5555, 0);
    @(negedge clock);
    chk("rd0_no_write", {busy, md_wb_en}, 2'b10);
    tick();
    @(negedge clock);
    chk("rd0_exit_wb", busy, 0);

    // no RDY: abort after exactly 40 BUSY cycles
    push(5'd30, 32'h4);
    issue(1'b0, 5'd6);
    repeat (39) tick();
    @(negedge clock);
    chk("timeout_not_early", {busy, md_wb_en}, 2'b10);
    tick();
    @(negedge clock);
    chk("timeout_abort", md_wb_en, 1);
    wait_idle("timeout_idle");

    // reset mid-BUSY discards the op; a late RDY is ignored
    issue(1'b0, 5'd8);
    repeat (5) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_reset_outputs", {23'd0, ctrl_MULT, ctrl_DIV, md_wb_en, md_wb_reg, md_wb_data, should_stall, busy}, 0);
    tick();
    reset = 1'b1; md_resultRDY = 1'b1; md_result = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_reset_quiet", {busy, md_wb_en}, 0);
      tick();
    end
    md_resultRDY = 1'b0; md_result = '0;
    push(5'd10, 32'h55);
    issue(1'b1, 5'd10);
    @(negedge clock);
    chk("post_reset_issue", {ctrl_MULT, ctrl_DIV, busy}, 3'b011);
    respond(2, 32'h55, 0);
    wait_idle("post_reset_idle");

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_scheduler.md
MULTDIV_SCHEDULER -- requirements
Module: multdiv_scheduler

Interface
REQ-001 SHALL have parameters: TIMEOUT, default 40, max BUSY cycles before abort; RSTATUS_REG, default 30, exception status register; MULT_EXC, default 4, mult overflow code; DIV_EXC, default 5, div error code.
REQ-002 SHALL have ports, one per line, as listed in REQ-002a to REQ-002q.
REQ-002a clock  in  1  single system clock, rising edge.
REQ-002b reset  in  1  asynchronous, active-low reset.
REQ-002c issue_mult  in  1  execute stage presents a mult this cycle.
REQ-002d issue_div  in  1  execute stage presents a div this cycle.
REQ-002e issue_rd  in  5  destination register of the issued op.
REQ-002f dec_valid  in  1  decode stage holds a live instruction.
REQ-002g dec_rs, dec_rt  in  5 each  decode source registers.
REQ-002h dec_is_multdiv  in  1  decode instruction is mult or div.
REQ-002i pipe_wb_en  in  1  main pipeline is writing the regfile this cycle.
REQ-002j md_resultRDY  in  1  multdiv unit result valid.
REQ-002k md_result  in  32  multdiv unit result.
REQ-002l md_exception  in  1  multdiv overflow or divide-by-zero.
REQ-002m ctrl_MULT, ctrl_DIV  out  1 each  start pulses to the multdiv unit.
REQ-002n md_wb_en  out  1  scheduler owns the regfile write port.
REQ-002o md_wb_reg  out  5  write register.
REQ-002p md_wb_data  out  32  write data.
REQ-002q should_stall, busy  out  1 each  hold decode; op in flight.

Function
REQ-003 SHALL implement states IDLE, BUSY and WB.
REQ-004 In IDLE, an issue is accepted on the clock edge where issue_mult or issue_div is high; if both are high, mult SHALL win and div SHALL be dropped.
REQ-005 On acceptance, the block SHALL latch issue_rd and the op type, then enter BUSY.
REQ-006 The matching ctrl_MULT or ctrl_DIV SHALL be registered and high for exactly the first BUSY cycle.
REQ-007 In BUSY, a 6-bit cycle counter SHALL start at 0 on entry and increment every cycle.
REQ-008 When md_resultRDY is high in BUSY, the block SHALL capture md_result and md_exception and enter WB on the next edge.
REQ-009 If the counter reaches TIMEOUT-1 without md_resultRDY, the block SHALL enter WB with the exception flag set; this is a forced abort.
REQ-010 In WB, when pipe_wb_en=0, md_wb_en SHALL be high for exactly one cycle, followed by a return to IDLE.
REQ-011 In WB, when pipe_wb_en=1, the block SHALL hold in WB; the pipeline has port priority.
REQ-012 Write target when there is no exception: md_wb_reg=latched rd and md_wb_data=result; if latched rd=0, md_wb_en SHALL stay low and the block SHALL still exit WB.
REQ-013 Write target on exception: md_wb_reg=RSTATUS_REG, and md_wb_data=MULT_EXC or DIV_EXC zero-extended to 32 bits.
REQ-014 md_wb_reg and md_wb_data SHALL be 0 whenever md_wb_en=0.
REQ-015 busy SHALL be 1 in BUSY and WB, otherwise 0.
REQ-016 should_stall SHALL be combinational and high when dec_valid AND (busy OR an issue is accepted this cycle) AND any of the following: dec_is_multdiv; dec_rs equals the pending rd with rd!=0; dec_rt equals the pending rd with rd!=0.
REQ-017 For REQ-016, "pending rd" SHALL be issue_rd during the acceptance cycle and the latched rd afterwards.
REQ-018 An issue arriving while busy SHALL be ignored; upstream guarantees it is stalled.
REQ-019 md_resultRDY outside BUSY SHALL be ignored.

Reset
REQ-020 When reset=0, the block SHALL asynchronously enter IDLE and clear the counter, latched rd, result and exception flag.
REQ-021 During reset, all outputs SHALL be 0.
REQ-022 A reset during BUSY or WB SHALL discard the op, and no md_wb_en pulse SHALL follow deassertion.
REQ-023 After reset deassertion, the first issue SHALL be accepted on the first rising edge.

Structure
REQ-024 State encodings, RSTATUS_REG, MULT_EXC, DIV_EXC and TIMEOUT SHALL live in the shared processor constants package.
REQ-025 The hazard comparator of REQ-016 SHALL be one sub-module, multdiv_hazard_check, which is purely combinational.
REQ-026 The block SHALL hold no regfile or datapath storage beyond the one result register.

Verification
REQ-027 Scenario: issue_mult, rd=5; RDY with result 0x0000_0030 after 17 cycles; pipe_wb_en=0 -> ctrl_MULT one cycle, md_wb_en one cycle, reg 5, data 0x30, then IDLE.
REQ-028 Scenario: issue_div, rd=7; RDY with md_exception=1 -> one write of reg 30, data 0x5.
REQ-029 Scenario: result ready with pipe_wb_en held at 1 for 3 cycles -> WB held, write occurs in the 4th cycle, no data lost.
REQ-030 Scenario: during BUSY with rd=9, decode presents rs=9, then rt=9, then an independent add, then rd=0 vs rs=0 -> should_stall = 1, 1, 0, 0.
REQ-031 Scenario: no RDY for 40 cycles after issue_mult -> abort, one write of reg 30, data 0x4.
REQ-032 Scenario: reset pulsed low mid-BUSY, then RDY arrives -> no md_wb_en, busy=0, next issue accepted normally.
